// File: rtl/memory_nport.sv
// memory_nport: parametrised single-write, multi-read synchronous memory.
//
// A hardware clear sequencer fills every word with CLEAR_VALUE after reset and
// on iClear. Accesses are only accepted in the ready state; anything requested
// while not ready, or in the same cycle as an accepted iClear, is dropped and
// flagged on oReject one cycle later.
//
// Ports:
//   Clock          rising-edge clock
//   Reset_n        asynchronous active-low reset
//   iClear         request a full clear (sampled only when ready)
//   iWriteEnable   write strobe
//   iAddress       write address
//   iDataIn        write data
//   iReadEn        per-channel read strobe
//   iReadAddress   per-channel read address, channel k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   oDataOut       per-channel registered read data, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   oDataValid     per-channel one-cycle valid pulse
//   oReady         memory accepts accesses
//   oReject        one-cycle pulse per dropped access cycle
//
// Build option:
//   MEMORY_WRITE_FIRST_EN  defined: same-cycle same-address read returns iDataIn
//                          undefined: read returns the previously stored word
module memory_nport #(
  parameter int unsigned           DATA_WIDTH  = 8,
  parameter int unsigned           ADDR_WIDTH  = 10,
  parameter int unsigned           NUM_READ    = 2,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                           Clock,
  input  logic                           Reset_n,
  input  logic                           iClear,
  input  logic                           iWriteEnable,
  input  logic [ADDR_WIDTH-1:0]          iAddress,
  input  logic [DATA_WIDTH-1:0]          iDataIn,
  input  logic [NUM_READ-1:0]            iReadEn,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] iReadAddress,
  output logic [NUM_READ*DATA_WIDTH-1:0] oDataOut,
  output logic [NUM_READ-1:0]            oDataValid,
  output logic                           oReady,
  output logic                           oReject
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [0:0] StInit  = 1'b0;
  localparam logic [0:0] StReady = 1'b1;

  logic [0:0]                     stateQ, stateD;
  logic [ADDR_WIDTH-1:0]          clrCntQ, clrCntD;
  logic                           readyQ, readyD;
  logic                           rejectQ, rejectD;
  logic [NUM_READ*DATA_WIDTH-1:0] dataOutQ, dataOutD;
  logic [NUM_READ-1:0]            validQ, validD;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  memWe;
  logic [ADDR_WIDTH-1:0] memWAddr;
  logic [DATA_WIDTH-1:0] memWData;

  logic                  accessReq;
  logic [DATA_WIDTH-1:0] readWord [NUM_READ];

  assign accessReq = iWriteEnable | (|iReadEn);

  for (genvar k = 0; k < NUM_READ; k++) begin : gRead
    logic [ADDR_WIDTH-1:0] rdAddr;
    assign rdAddr = iReadAddress[k*ADDR_WIDTH +: ADDR_WIDTH];
`ifdef MEMORY_WRITE_FIRST_EN
    // Bypass only matters when the write is actually committed, which is the
    // only case in which the read is committed too.
    assign readWord[k] = (iWriteEnable && (rdAddr == iAddress)) ? iDataIn : mem[rdAddr];
`else
    assign readWord[k] = mem[rdAddr];
`endif
  end

  always_comb begin
    stateD   = stateQ;
    clrCntD  = clrCntQ;
    readyD   = readyQ;
    rejectD  = 1'b0;
    dataOutD = dataOutQ;
    validD   = '0;
    memWe    = 1'b0;
    memWAddr = iAddress;
    memWData = iDataIn;

    unique case (stateQ)
      StInit: begin
        memWe    = 1'b1;
        memWAddr = clrCntQ;
        memWData = CLEAR_VALUE;
        clrCntD  = clrCntQ + ADDR_WIDTH'(1);
        rejectD  = accessReq;
        if (&clrCntQ) begin
          stateD = StReady;
          readyD = 1'b1;
        end
      end
      StReady: begin
        if (iClear) begin
          stateD  = StInit;
          clrCntD = '0;
          readyD  = 1'b0;
          rejectD = accessReq;
        end else begin
          memWe = iWriteEnable;
          for (int k = 0; k < NUM_READ; k++) begin
            if (iReadEn[k]) begin
              dataOutD[k*DATA_WIDTH +: DATA_WIDTH] = readWord[k];
              validD[k] = 1'b1;
            end
          end
        end
      end
      default: begin
        stateD  = StInit;
        clrCntD = '0;
        readyD  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      stateQ   <= StInit;
      clrCntQ  <= '0;
      readyQ   <= 1'b0;
      rejectQ  <= 1'b0;
      dataOutQ <= '0;
      validQ   <= '0;
    end else begin
      stateQ   <= stateD;
      clrCntQ  <= clrCntD;
      readyQ   <= readyD;
      rejectQ  <= rejectD;
      dataOutQ <= dataOutD;
      validQ   <= validD;
    end
  end

  // Array is not reset; the clear sequencer initialises it.
  always_ff @(posedge Clock) begin
    if (memWe) begin
      mem[memWAddr] <= memWData;
    end
  end

  assign oDataOut   = dataOutQ;
  assign oDataValid = validQ;
  assign oReady     = readyQ;
  assign oReject    = rejectQ;

endmodule

// File: tb/tb_memory_nport.sv
module tb_memory_nport;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;
  localparam int unsigned NR = 2;
  localparam int unsigned DEPTH = 16;
  localparam logic [7:0] CLR = 8'hA5;

`ifdef MEMORY_WRITE_FIRST_EN
  localparam logic [7:0] COLL = 8'h22;
`else
  localparam logic [7:0] COLL = 8'h11;
`endif

  logic          Clock;
  logic          Reset_n;
  logic          iClear;
  logic          iWriteEnable;
  logic [AW-1:0] iAddress;
  logic [DW-1:0] iDataIn;
  logic [NR-1:0] iReadEn;
  logic [NR*AW-1:0] iReadAddress;
  logic [NR*DW-1:0] oDataOut;
  logic [NR-1:0] oDataValid;
  logic          oReady;
  logic          oReject;

  memory_nport #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NUM_READ   (NR),
    .CLEAR_VALUE(CLR)
  ) dut (
    .Clock       (Clock),
    .Reset_n     (Reset_n),
    .iClear      (iClear),
    .iWriteEnable(iWriteEnable),
    .iAddress    (iAddress),
    .iDataIn     (iDataIn),
    .iReadEn     (iReadEn),
    .iReadAddress(iReadAddress),
    .oDataOut    (oDataOut),
    .oDataValid  (oDataValid),
    .oReady      (oReady),
    .oReject     (oReject)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct packed {
    logic       we;
    logic [3:0] wAddr;
    logic [7:0] wData;
    logic [1:0] rEn;
    logic [3:0] rAddr0;
    logic [3:0] rAddr1;
    logic [1:0] expValid;
    logic [15:0] expData;  // {channel1, channel0}
    logic       expReject;
    logic       expReady;
  } vec_t;

  vec_t vecs [9];

  int nChecks = 0;
  int nFail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one edge; outputs are stable at #1 after it, inputs set then
  // are sampled on the next edge.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle();
    iClear       = 1'b0;
    iWriteEnable = 1'b0;
    iAddress     = '0;
    iDataIn      = '0;
    iReadEn      = '0;
    iReadAddress = '0;
  endtask

  // Counts edges from now until oReady is seen high, bounded.
  task automatic countToReady(output int edges);
    edges = 0;
    for (int i = 1; i <= 4 * DEPTH; i++) begin
      tick();
      if (oReady) begin
        edges = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    idle();
    Reset_n = 1'b0;

    // Reset state
    tick();
    tick();
    check("reset oReady", 32'(oReady), 32'd0);
    check("reset oReject", 32'(oReject), 32'd0);
    check("reset oDataValid", 32'(oDataValid), 32'd0);
    check("reset oDataOut", 32'(oDataOut), 32'd0);

    // Init duration: low through edge 15, high after edge 16
    Reset_n = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      tick();
      if (i == DEPTH - 1) check("init ready edge15", 32'(oReady), 32'd0);
      if (i == DEPTH)     check("init ready edge16", 32'(oReady), 32'd1);
    end

    // Table-driven accesses in READY
    vecs[0] = '{1'b0, 4'd0, 8'h00, 2'b01, 4'd7, 4'd0, 2'b01, {8'h00, CLR},   1'b0, 1'b1};
    vecs[1] = '{1'b0, 4'd0, 8'h00, 2'b00, 4'd0, 4'd0, 2'b00, {8'h00, CLR},   1'b0, 1'b1};
    vecs[2] = '{1'b1, 4'd3, 8'h3C, 2'b00, 4'd0, 4'd0, 2'b00, {8'h00, CLR},   1'b0, 1'b1};
    vecs[3] = '{1'b0, 4'd0, 8'h00, 2'b11, 4'd3, 4'd3, 2'b11, {8'h3C, 8'h3C}, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 4'd5, 8'h11, 2'b00, 4'd0, 4'd0, 2'b00, {8'h3C, 8'h3C}, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 4'd5, 8'h22, 2'b01, 4'd5, 4'd0, 2'b01, {8'h3C, COLL},  1'b0, 1'b1};
    vecs[6] = '{1'b0, 4'd0, 8'h00, 2'b10, 4'd0, 4'd5, 2'b10, {8'h22, COLL},  1'b0, 1'b1};
    vecs[7] = '{1'b1, 4'd9, 8'hFF, 2'b00, 4'd0, 4'd0, 2'b00, {8'h22, COLL},  1'b0, 1'b1};
    vecs[8] = '{1'b0, 4'd0, 8'h00, 2'b11, 4'd9, 4'd0, 2'b11, {CLR, 8'hFF},   1'b0, 1'b1};

    for (int v = 0; v < 9; v++) begin
      iWriteEnable = vecs[v].we;
      iAddress     = vecs[v].wAddr;
      iDataIn      = vecs[v].wData;
      iReadEn      = vecs[v].rEn;
      iReadAddress = {vecs[v].rAddr1, vecs[v].rAddr0};
      tick();
      check($sformatf("vec%0d valid", v), 32'(oDataValid), 32'(vecs[v].expValid));
      check($sformatf("vec%0d data", v), 32'(oDataOut), 32'(vecs[v].expData));
      check($sformatf("vec%0d reject", v), 32'(oReject), 32'(vecs[v].expReject));
      check($sformatf("vec%0d ready", v), 32'(oReady), 32'(vecs[v].expReady));
    end
    idle();

    // Clear in READY together with a read of address 9
    iClear       = 1'b1;
    iReadEn      = 2'b01;
    iReadAddress = {4'd0, 4'd9};
    tick();
    idle();
    check("clear reject", 32'(oReject), 32'd1);
    check("clear ready low", 32'(oReady), 32'd0);
    check("clear read dropped", 32'(oDataValid), 32'd0);
    tick();
    check("clear reject one cycle", 32'(oReject), 32'd0);
    countToReady(n);
    // First edge after acceptance already counted above
    check("clear duration", 32'(n), 32'(DEPTH - 1));
    iReadEn      = 2'b01;
    iReadAddress = {4'd0, 4'd9};
    tick();
    idle();
    check("post-clear addr9 valid", 32'(oDataValid), 32'd1);
    check("post-clear addr9 data", 32'(oDataOut[7:0]), 32'(CLR));

    // Asynchronous reset while READY clears outputs immediately
    #2;
    Reset_n = 1'b0;
    #1;
    check("async reset data", 32'(oDataOut), 32'd0);
    check("async reset ready", 32'(oReady), 32'd0);

    // Reject during init: write at edge 2 after release
    tick();
    Reset_n = 1'b1;
    tick();                     // edge 1
    iWriteEnable = 1'b1;
    iAddress     = 4'd0;
    iDataIn      = 8'h77;
    tick();                     // edge 2
    idle();
    check("init reject", 32'(oReject), 32'd1);
    tick();                     // edge 3
    check("init reject one cycle", 32'(oReject), 32'd0);
    countToReady(n);
    check("init ready after reject", 32'(n), 32'(DEPTH - 3));
    iReadEn      = 2'b10;
    iReadAddress = {4'd0, 4'd0};
    tick();
    idle();
    check("addr0 after rejected write", 32'(oDataOut[15:8]), 32'(CLR));
    check("addr0 valid ch1", 32'(oDataValid), 32'd2);

    // Reset mid-init at edge 8, then full DEPTH edges after release
    Reset_n = 1'b0;
    tick();
    Reset_n = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    Reset_n = 1'b0;
    #1;
    check("mid-init reset ready", 32'(oReady), 32'd0);
    tick();
    Reset_n = 1'b1;
    countToReady(n);
    check("restart init duration", 32'(n), 32'(DEPTH));

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
